// File: rtl/mdu_sequencer.sv
// Control sequencer for the iterative multiply/divide unit: decodes MULTU/DIVU/MADDU/MSUBU,
// runs a WIDTH-cycle iteration count and issues the HI/LO write command on completion.
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [5:0]    opcode_i,
    input  logic [5:0]    funct_i,
    input  logic          issue_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          mf_stall_o,
    output logic          unit_start_o,
    output logic          unit_div_o,
    output logic [CW-1:0] iter_o,
    output logic [1:0]    hilo_op_o,
    output logic          done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

    localparam logic [CW-1:0] IterLast = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [1:0]    mode_q, mode_d;
    logic          div_q, div_d;

    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_div;
    logic          op_is_mf;

    always_comb begin
        op_valid = 1'b0;
        op_code  = 2'b00;
        op_div   = 1'b0;
        op_is_mf = 1'b0;
        if (opcode_i == 6'd0) begin
            case (funct_i)
                6'd25: begin op_valid = 1'b1; op_code = 2'b01; end
                6'd27: begin op_valid = 1'b1; op_code = 2'b01; op_div = 1'b1; end
                6'd16, 6'd18: op_is_mf = 1'b1;
                default: ;
            endcase
        end else if (opcode_i == 6'd28) begin
            case (funct_i)
                6'd1: begin op_valid = 1'b1; op_code = 2'b10; end
                6'd5: begin op_valid = 1'b1; op_code = 2'b11; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        mode_d  = mode_q;
        div_d   = div_q;
        if (flush_i) begin
            // Cancels without touching the latched mode; HI/LO is never written.
            state_d = StIdle;
            iter_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (issue_i && op_valid) begin
                        state_d = StRun;
                        iter_d  = '0;
                        mode_d  = op_code;
                        div_d   = op_div;
                    end
                end
                StRun: begin
                    if (iter_q == IterLast) begin
                        state_d = StWb;
                        iter_d  = '0;
                    end else begin
                        iter_d = iter_q + CW'(1);
                    end
                end
                StWb:    state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            iter_q  <= '0;
            mode_q  <= 2'b00;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        busy_o       = (state_q != StIdle);
        mf_stall_o   = busy_o & issue_i & op_is_mf;
        unit_start_o = (state_q == StRun) && (iter_q == '0);
        unit_div_o   = div_q;
        iter_o       = iter_q;
        done_o       = (state_q == StWb) && !flush_i;
        hilo_op_o    = done_o ? mode_q : 2'b00;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: two instances (WIDTH 32 and 5) checked every cycle against a model
// that tracks elapsed cycles since acceptance.
module tb_mdu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opc [2];
    logic [5:0] fnc [2];
    logic       iss [2];
    logic       fls [2];
    logic       busy [2];
    logic       mf [2];
    logic       us [2];
    logic       dv [2];
    logic [1:0] hilo [2];
    logic       done [2];
    logic [4:0] iter32;
    logic [2:0] iter5;

    always #5 clk = ~clk;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_i(rst), .opcode_i(opc[0]), .funct_i(fnc[0]), .issue_i(iss[0]),
        .flush_i(fls[0]), .busy_o(busy[0]), .mf_stall_o(mf[0]), .unit_start_o(us[0]),
        .unit_div_o(dv[0]), .iter_o(iter32), .hilo_op_o(hilo[0]), .done_o(done[0])
    );

    mdu_sequencer #(.WIDTH(5)) dut5 (
        .clk_i(clk), .reset_i(rst), .opcode_i(opc[1]), .funct_i(fnc[1]), .issue_i(iss[1]),
        .flush_i(fls[1]), .busy_o(busy[1]), .mf_stall_o(mf[1]), .unit_start_o(us[1]),
        .unit_div_o(dv[1]), .iter_o(iter5), .hilo_op_o(hilo[1]), .done_o(done[1])
    );

    int          checks = 0;
    int          passed = 0;
    int          wdt [2] = '{32, 5};
    int          m_t [2] = '{0, 0};   // cycles since accept; 0 = idle
    logic        m_div [2] = '{1'b0, 1'b0};
    logic [1:0]  m_code [2] = '{2'b00, 2'b00};
    logic [11:0] exp_vec [2];

    // {valid, div, hilo code}
    function automatic logic [3:0] dec(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0 && fn == 6'd25) return 4'b1001;
        if (op == 6'd0 && fn == 6'd27) return 4'b1101;
        if (op == 6'd28 && fn == 6'd1) return 4'b1010;
        if (op == 6'd28 && fn == 6'd5) return 4'b1011;
        return 4'b0000;
    endfunction

    function automatic logic is_mf(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn == 6'd16 || fn == 6'd18);
    endfunction

    function automatic logic [11:0] act(input int d);
        if (d == 0) return {busy[0], mf[0], us[0], dv[0], iter32, hilo[0], done[0]};
        return {busy[1], mf[1], us[1], dv[1], 2'b00, iter5, hilo[1], done[1]};
    endfunction

    // Drive one cycle on instance d (other instance idle), compute expectations, advance model.
    task automatic drive(input int d, input logic [5:0] op, input logic [5:0] fn,
                         input logic is, input logic fl, input logic r);
        @(negedge clk);
        rst = r;
        for (int k = 0; k < 2; k++) begin
            opc[k] = (k == d) ? op : 6'd0;
            fnc[k] = (k == d) ? fn : 6'd0;
            iss[k] = (k == d) ? is : 1'b0;
            fls[k] = (k == d) ? fl : 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            int   t;
            int   w;
            logic eb;
            logic ewb;
            logic [3:0] dd;
            t   = m_t[k];
            w   = wdt[k];
            eb  = (t != 0);
            ewb = (t == w + 1) && !fls[k];
            exp_vec[k] = {eb, eb & iss[k] & is_mf(opc[k], fnc[k]), t == 1, m_div[k],
                          5'((t >= 1 && t <= w) ? t - 1 : 0), ewb ? m_code[k] : 2'b00, ewb};
            dd = dec(opc[k], fnc[k]);
            if (r) begin
                m_t[k] = 0; m_div[k] = 1'b0; m_code[k] = 2'b00;
            end else if (fls[k]) begin
                m_t[k] = 0;
            end else if (t == 0) begin
                if (iss[k] && dd[3]) begin
                    m_t[k] = 1; m_div[k] = dd[2]; m_code[k] = dd[1:0];
                end
            end else if (t == w + 1) begin
                m_t[k] = 0;
            end else begin
                m_t[k] = t + 1;
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        drive(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        drive(0, 6'd0, 6'd16, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act(k) !== 12'h000) $display("FAIL reset dut%0d: got %b want %b", k, act(k), 12'h000);
            else passed++;
        end
    endtask

    task automatic test_multu();
        int done_at = -1;
        drive(0, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 35; i++) begin
            drive(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            if (done[0]) done_at = i;
            checks++;
            if (act(0) !== exp_vec[0]) $display("FAIL multu cyc %0d: got %b want %b", i, act(0), exp_vec[0]);
            else passed++;
        end
        checks++;
        if (done_at !== 33) $display("FAIL multu_done_cycle: got %0d want 33", done_at);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int         d_at [2] = '{-1, -1};
        logic [1:0] h_at [2] = '{2'b00, 2'b00};
        int         n = 0;
        drive(0, 6'd28, 6'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            drive(0, 6'd28, 6'd5, i <= 34, 1'b0, 1'b0);
            if (done[0] && n < 2) begin d_at[n] = i; h_at[n] = hilo[0]; n++; end
            checks++;
            if (act(0) !== exp_vec[0]) $display("FAIL b2b cyc %0d: got %b want %b", i, act(0), exp_vec[0]);
            else passed++;
        end
        checks++;
        if ({h_at[0], h_at[1]} !== 4'b1011 || d_at[1] - d_at[0] !== 34 || d_at[0] !== 33)
            $display("FAIL b2b_wb: got hilo %b/%b at %0d/%0d want 10/11 at 33/67",
                     h_at[0], h_at[1], d_at[0], d_at[1]);
        else passed++;
    endtask

    task automatic test_divu5();
        int done_at = -1;
        drive(1, 6'd0, 6'd27, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            drive(1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            if (done[1]) done_at = i;
            checks++;
            if (act(1) !== exp_vec[1]) $display("FAIL divu5 cyc %0d: got %b want %b", i, act(1), exp_vec[1]);
            else passed++;
        end
        checks++;
        if (done_at !== 6 || dv[1] !== 1'b1) $display("FAIL divu5_wb: got done %0d div %b want 6 1", done_at, dv[1]);
        else passed++;
    endtask

    task automatic test_mf_stall();
        drive(0, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 35; i++) begin
            drive(0, 6'd0, (i % 2) ? 6'd16 : 6'd18, 1'b1, 1'b0, 1'b0);
            checks++;
            if (act(0) !== exp_vec[0]) $display("FAIL mf_stall cyc %0d: got %b want %b", i, act(0), exp_vec[0]);
            else passed++;
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        for (int rep = 0; rep < 2; rep++) begin
            drive(0, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0);
            for (int i = 1; i <= 36; i++) begin
                drive(0, 6'd0, 6'd25, 1'b0, (rep == 0) ? (i == 8) : (i == 33), 1'b0);
                if (done[0] || hilo[0] !== 2'b00) dones++;
                checks++;
                if (act(0) !== exp_vec[0]) $display("FAIL flush%0d cyc %0d: got %b want %b", rep, i, act(0), exp_vec[0]);
                else passed++;
            end
        end
        drive(0, 6'd0, 6'd25, 1'b1, 1'b1, 1'b0);
        drive(0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act(0) !== exp_vec[0] || busy[0] !== 1'b0 || dones !== 0)
            $display("FAIL flush_idle: got %b busy %b dones %0d want %b busy 0 dones 0",
                     act(0), busy[0], dones, exp_vec[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        drive(0, 6'd0, 6'd25, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 26; i++) begin
            drive(0, 6'd0, 6'd25, i == 21, 1'b0, i == 21);
            if (i > 21 && (us[0] || done[0])) starts++;
            checks++;
            if (act(0) !== exp_vec[0]) $display("FAIL reset_mid cyc %0d: got %b want %b", i, act(0), exp_vec[0]);
            else passed++;
        end
        checks++;
        if (starts !== 0) $display("FAIL reset_mid_pulses: got %0d want 0", starts);
        else passed++;
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'd0, 6'd0, 6'd28, 6'd28, 6'd0, 6'd0, 6'd0, 6'd28};
        logic [5:0] fns [8] = '{6'd25, 6'd27, 6'd1, 6'd5, 6'd16, 6'd18, 6'd0, 6'd0};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 300; i++) begin
                int         s;
                logic [5:0] op;
                logic [5:0] fn;
                s  = int'($urandom_range(0, 9));
                op = (s < 8) ? ops[s] : 6'($urandom);
                fn = (s < 8) ? fns[s] : 6'($urandom);
                drive(d, op, fn, 1'($urandom), $urandom_range(0, 15) == 0,
                      $urandom_range(0, 99) == 0);
                checks++;
                if (act(d) !== exp_vec[d])
                    $display("FAIL random dut%0d cyc %0d: got %b want %b", d, i, act(d), exp_vec[d]);
                else passed++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            opc[k] = 6'd0; fnc[k] = 6'd0; iss[k] = 1'b0; fls[k] = 1'b0;
        end
        test_reset();
        test_multu();
        test_back_to_back();
        test_divu5();
        test_mf_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
